wide_exec256: RTL and testbench
===============================

Name: wide_exec256

Overview:
- Multi-cycle 256-bit execute stage sitting between register-file read and writeback.
- Consumes the two 256-bit read operands RD1/RD2 and the destination index.
- Produces WB, WE and A3 for the 256-bit register file's write port.
- Processes operands one SLICE_W-bit slice per cycle, low slice first, so a single narrow datapath serves the full 256-bit width.

Parameters:
- SLICE_W, 32: slice width in bits; must divide 256; NSLICE = 256/SLICE_W (default 8).

Ports:
- CLK  input  1  single clock for all state, rising edge.
- RST  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- OP  input  3  operation code, latched with START.
- A3_IN  input  5  destination register index, latched with START.
- RS1  input  256  operand 1 (from RD1), latched with START.
- RS2  input  256  operand 2 (from RD2), latched with START.
- BUSY  output  1  high while an operation is in flight, DONE cycle included.
- DONE  output  1  one-cycle completion pulse.
- WE  output  1  write enable to the register file; one-cycle pulse with DONE.
- A3  output  5  destination index accompanying WE.
- WB  output  256  result; holds its value until the next completion.
- CARRY  output  1  final carry-out of ADD/SUB; 0 for other ops.

Behaviour:
- Reset (RST low, asynchronous):
  - State = IDLE.
  - BUSY, DONE, WE, CARRY = 0; A3 = 0; WB = 0.
  - Internal operand and result registers, slice counter and carry cleared.
- Reset asserted mid-operation aborts the operation: no WE pulse, WB stays 0 after release.
- States:
  - IDLE -> RUN on a rising edge with START = 1. That edge latches OP, A3_IN, RS1, RS2, sets counter = 0, and sets carry-in = 1 for SUB, else 0.
  - RUN: each edge computes slice[counter] into the result register and increments counter. The edge computing slice NSLICE-1 moves to FIN.
  - FIN: DONE = 1 for exactly one cycle. WE = 1 unless OP is reserved. WB, A3 and CARRY are valid this cycle. Next edge -> IDLE.
- Latency: START accepted at edge k; DONE/WE high during the cycle after edge k+NSLICE. Default: the 9th cycle after acceptance.
- Back-to-back issue: earliest next acceptance is the edge leaving FIN (START held high there is ignored); the first edge in IDLE with START = 1 is accepted.
- BUSY is high in RUN and FIN.
- START in RUN/FIN is ignored. Operand input changes after acceptance have no effect.
- OP encoding:
  - 000 XOR, 001 AND, 010 OR: bitwise.
  - 011 ADD: RS1 + RS2 mod 2^256. Carry chained slice to slice via a 1-bit register.
  - 100 SUB: RS1 + ~RS2 + 1 mod 2^256. CARRY = 1 means no borrow.
  - 101 ROTW: rotate RS1 left by one slice, i.e. result slice i = RS1 slice (i-1) mod NSLICE. RS2 ignored.
  - 110, 111 reserved: full sequence runs, WB = 0, DONE pulses, WE = 0, CARRY = 0.
- WB and CARRY update only on the edge entering FIN; they never show partial results. A3 updates on the same edge.

Test Plan:
- ADD carry ripple: RS1 = 2^256-1, RS2 = 1, OP = 011, A3_IN = 2 -> after 9 cycles WB = 0, CARRY = 1, WE = 1 for one cycle, A3 = 2, BUSY low the following cycle.
- SUB borrow: RS1 = 0, RS2 = 1, OP = 100 -> WB = 2^256-1, CARRY = 0. Then RS1 = 5, RS2 = 3 -> WB = 2, CARRY = 1.
- Bitwise and rotate:
  - RS1 = {8{32'hAAAA5555}}, RS2 = {8{32'hFFFF0000}}: XOR -> {8{32'h5555_5555}}; AND -> {8{32'hAAAA0000}}.
  - ROTW with RS1 words 7..0 = 7,6,...,0 -> WB words 7..0 = 6,5,4,3,2,1,0,7.
- START abuse:
  - START held high continuously with OP = 000 -> accepted once per 10 cycles; exactly one WE pulse per operation.
  - Changed RS1 during RUN does not alter WB.
- Reset mid-op: assert RST low at RUN cycle 4 -> BUSY, DONE, WE, WB, A3 = 0 immediately; no WE after release. A subsequent ADD 1 + 1 gives WB = 2.
- Reserved OP = 110 -> DONE pulses at cycle 9, WE stays 0, WB = 0, CARRY = 0.

Source files
------------

// File: rtl/wide_exec256.sv
// wide_exec256 -- multi-cycle 256-bit execute stage between register-file
// read and writeback. Operands are processed one SLICE_W-bit slice per cycle,
// low slice first, through a single narrow datapath.
//
// Ports:
//   CLK    rising-edge clock for all state
//   RST    asynchronous active-low reset
//   START  request, sampled only in IDLE
//   OP     operation code (latched with START)
//   A3_IN  destination register index (latched with START)
//   RS1    256-bit operand 1 (latched with START)
//   RS2    256-bit operand 2 (latched with START)
//   BUSY   high in RUN and FIN
//   DONE   one-cycle completion pulse (FIN)
//   WE     register-file write enable, pulses with DONE unless OP is reserved
//   A3     destination index accompanying WE
//   WB     result, held until the next completion
//   CARRY  final carry-out of ADD/SUB, 0 otherwise
module wide_exec256 #(
  parameter int SLICE_W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [2:0]   OP,
  input  logic [4:0]   A3_IN,
  input  logic [255:0] RS1,
  input  logic [255:0] RS2,
  output logic         BUSY,
  output logic         DONE,
  output logic         WE,
  output logic [4:0]   A3,
  output logic [255:0] WB,
  output logic         CARRY
);

  localparam int NSLICE = 256 / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  typedef enum logic [2:0] {
    OP_XOR  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_ROTW = 3'b101,
    OP_RES6 = 3'b110,
    OP_RES7 = 3'b111
  } op_t;

  state_t         state, state_nx;
  op_t            op_q;
  logic [4:0]     a3_q;
  logic [255:0]   rs1_q, rs2_q, res_q, res_nx;
  logic [CW-1:0]  cnt;
  logic           cy;

  logic [SLICE_W-1:0] sa, sb, srot, slice;
  logic [SLICE_W:0]   sum;
  logic               last, reserved, arith;

  assign last     = (cnt == CW'(NSLICE - 1));
  assign reserved = (op_q == OP_RES6) || (op_q == OP_RES7);
  assign arith    = (op_q == OP_ADD) || (op_q == OP_SUB);

  // Slice select: srot is the slice below the current one (wrapping), which
  // realises a one-slice left rotation of RS1.
  always_comb begin
    sa   = '0;
    sb   = '0;
    srot = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        sa   = rs1_q[i*SLICE_W +: SLICE_W];
        sb   = rs2_q[i*SLICE_W +: SLICE_W];
        srot = rs1_q[((i + NSLICE - 1) % NSLICE)*SLICE_W +: SLICE_W];
      end
    end
  end

  // SUB reuses the adder with RS2 inverted; the +1 comes from the carry
  // register being preset to 1 at acceptance.
  always_comb begin
    sum = {1'b0, sa} + {1'b0, (op_q == OP_SUB) ? ~sb : sb} + {{SLICE_W{1'b0}}, cy};
    case (op_q)
      OP_XOR:          slice = sa ^ sb;
      OP_AND:          slice = sa & sb;
      OP_OR:           slice = sa | sb;
      OP_ADD, OP_SUB:  slice = sum[SLICE_W-1:0];
      OP_ROTW:         slice = srot;
      default:         slice = '0;
    endcase
  end

  // Result register with the current slice merged in; on the last slice this
  // is the complete result that is published to WB.
  always_comb begin
    res_nx = res_q;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) res_nx[i*SLICE_W +: SLICE_W] = slice;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    WE       = 1'b0;
    case (state)
      S_IDLE: if (START) state_nx = S_RUN;
      S_RUN: begin
        BUSY = 1'b1;
        if (last) state_nx = S_FIN;
      end
      S_FIN: begin
        BUSY     = 1'b1;
        DONE     = 1'b1;
        WE       = !reserved;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_q  <= OP_XOR;
      a3_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      res_q <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      A3    <= '0;
      WB    <= '0;
      CARRY <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            op_q  <= op_t'(OP);
            a3_q  <= A3_IN;
            rs1_q <= RS1;
            rs2_q <= RS2;
            cnt   <= '0;
            cy    <= (OP == OP_SUB);
          end
        end
        S_RUN: begin
          res_q <= res_nx;
          cnt   <= cnt + CW'(1);
          cy    <= sum[SLICE_W];
          if (last) begin
            WB    <= reserved ? '0 : res_nx;
            CARRY <= arith & sum[SLICE_W];
            A3    <= a3_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_exec256.sv
module tb_wide_exec256;

  logic         CLK;
  logic         RST;
  logic         START;
  logic [2:0]   OP;
  logic [4:0]   A3_IN;
  logic [255:0] RS1, RS2;
  logic         BUSY, DONE, WE, CARRY;
  logic [4:0]   A3;
  logic [255:0] WB;

  int n_vec = 0;
  int n_err = 0;

  wide_exec256 #(.SLICE_W(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A3_IN(A3_IN),
    .RS1(RS1), .RS2(RS2), .BUSY(BUSY), .DONE(DONE), .WE(WE),
    .A3(A3), .WB(WB), .CARRY(CARRY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE, scramble the inputs right after acceptance,
  // then check latency, the completion cycle and the cycle after it.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [4:0] a3,
                        input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] exp_wb, input logic exp_c, input logic exp_we);
    int n;
    @(negedge CLK);
    START = 1'b1; OP = op; A3_IN = a3; RS1 = a; RS2 = b;
    @(negedge CLK);
    START = 1'b0; OP = ~op; A3_IN = ~a3; RS1 = ~a; RS2 = ~b;
    chk({tag, "_busy_run"}, BUSY, 1'b1);
    n = 1;
    while (DONE !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_we"},      WE, exp_we);
    chk({tag, "_a3"},      A3, a3);
    chk({tag, "_wb"},      WB, exp_wb);
    chk({tag, "_carry"},   CARRY, exp_c);
    @(negedge CLK);
    chk({tag, "_done_off"}, DONE, 1'b0);
    chk({tag, "_we_off"},   WE, 1'b0);
    chk({tag, "_busy_off"}, BUSY, 1'b0);
    chk({tag, "_wb_hold"},  WB, exp_wb);
  endtask

  initial begin
    logic [255:0] ones, x, y, rot_in, rot_exp, expv;
    int we_cnt;

    ones = '1;
    x = {8{32'hAAAA5555}};
    y = {8{32'hFFFF0000}};
    for (int i = 0; i < 8; i++) begin
      rot_in[i*32 +: 32]  = 32'(i);
      rot_exp[i*32 +: 32] = 32'((i + 7) % 8);
    end

    RST = 1'b0; START = 1'b0; OP = '0; A3_IN = '0; RS1 = '0; RS2 = '0;
    #12;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_we", WE, 1'b0);
    chk("rst_a3", A3, 5'd0);
    chk("rst_wb", WB, '0);
    chk("rst_carry", CARRY, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    run_op("add_ripple", 3'b011, 5'd2, ones, 256'd1, '0, 1'b1, 1'b1);
    run_op("sub_borrow", 3'b100, 5'd3, '0, 256'd1, ones, 1'b0, 1'b1);
    run_op("sub_5m3",    3'b100, 5'd5, 256'd5, 256'd3, 256'd2, 1'b1, 1'b1);
    run_op("xor",        3'b000, 5'd6, x, y, {8{32'h55555555}}, 1'b0, 1'b1);
    run_op("and",        3'b001, 5'd7, x, y, {8{32'hAAAA0000}}, 1'b0, 1'b1);
    run_op("or",         3'b010, 5'd8, x, y, {8{32'hFFFF5555}}, 1'b0, 1'b1);
    run_op("rotw",       3'b101, 5'd31, rot_in, ones, rot_exp, 1'b0, 1'b1);
    expv = 256'd30;
    run_op("add_scramble", 3'b011, 5'd1, 256'd10, 256'd20, expv, 1'b0, 1'b1);

    // START held high: one acceptance every 10 cycles, one WE per operation.
    @(negedge CLK);
    START = 1'b1; OP = 3'b000; A3_IN = 5'd9; RS1 = x; RS2 = y;
    we_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (WE === 1'b1) begin
        we_cnt++;
        chk("hold_we_phase", n % 10, 9);
        chk("hold_wb", WB, {8{32'h55555555}});
        chk("hold_a3", A3, 5'd9);
      end
    end
    START = 1'b0;
    chk("hold_we_count", we_cnt, 4);
    @(negedge CLK);
    chk("hold_idle", BUSY, 1'b0);

    // Reset in the middle of an operation aborts it.
    @(negedge CLK);
    START = 1'b1; OP = 3'b011; A3_IN = 5'd7; RS1 = 256'd100; RS2 = 256'd200;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", DONE, 1'b0);
    chk("abort_we", WE, 1'b0);
    chk("abort_wb", WB, '0);
    chk("abort_a3", A3, 5'd0);
    @(negedge CLK);
    RST = 1'b1;
    we_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge CLK);
      if (WE === 1'b1 || DONE === 1'b1) we_cnt++;
    end
    chk("abort_no_we", we_cnt, 0);
    chk("abort_wb_after", WB, '0);

    run_op("add_1p1", 3'b011, 5'd1, 256'd1, 256'd1, 256'd2, 1'b0, 1'b1);
    run_op("res110",  3'b110, 5'd4, ones, x, '0, 1'b0, 1'b0);
    run_op("add_c",   3'b011, 5'd10, ones, ones, {ones[255:1], 1'b0}, 1'b1, 1'b1);
    run_op("res111",  3'b111, 5'd11, x, y, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
